// File: rtl/ps2_frame_rx_if.sv
// Byte-stream hand-off between the PS/2 receiver FIFO and the keyboard consumer.
// The receiver drives the show-ahead head byte and occupancy.
// The consumer drives the pop request.
interface ps2_frame_rx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd;
  logic [7:0]    rdata;
  logic          valid;
  logic [CW-1:0] count;

  modport master (input rd, output rdata, output valid, output count);
  modport slave  (output rd, input rdata, input valid, input count);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Pad synchronisers feed a kc deglitch filter, which feeds an 11-bit frame
// deserialiser (start, 8 data LSB-first, odd parity, stop).
// Good bytes land in a show-ahead FIFO, and errors are held in sticky flags.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          kc,
  input  logic          kd,
  input  logic          clr_err,
  output logic          frame_err,
  output logic          parity_err,
  output logic          overrun,
  ps2_frame_rx_if.master fifo
);

  localparam int FCW = $clog2(FILTER_LEN);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic           kc_meta_q, kc_meta_d, kc_sync_q, kc_sync_d;
  logic           kd_meta_q, kd_meta_d, kd_sync_q, kd_sync_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           kc_filt_q, kc_filt_d, kc_dly_q, kc_dly_d;
  logic           strobe;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           push, frame_ev, parity_ev, overrun_ev;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop, full, not_empty;

  logic           frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic           overrun_q, overrun_d;

  // Synchronise the pads and debounce kc; a falling edge of the filtered clock yields a one-cycle strobe.
  always_comb begin
    kc_meta_d  = kc;
    kc_sync_d  = kc_meta_q;
    kd_meta_d  = kd;
    kd_sync_d  = kd_meta_q;
    filt_cnt_d = '0;
    kc_filt_d  = kc_filt_q;
    kc_dly_d   = kc_filt_q;
    strobe     = kc_dly_q & ~kc_filt_q;
    if (kc_sync_q != kc_filt_q) begin
      if (filt_cnt_q == FILT_MAX) begin
        kc_filt_d = kc_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Frame deserialiser; timeout aborts a stalled frame in any non-idle state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    push      = 1'b0;
    frame_ev  = 1'b0;
    parity_ev = 1'b0;
    if (state_q != IDLE && !strobe) begin
      tmo_d = tmo_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          if (!kd_sync_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_ev = 1'b1;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          shift_d[bit_cnt_q] = kd_sync_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          par_d   = kd_sync_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_d = IDLE;
          if (!kd_sync_q) begin
            frame_ev = 1'b1;
          end else if ((^shift_q ^ par_q) != 1'b1) begin
            parity_ev = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !strobe && tmo_q == TMO_MAX) begin
      state_d  = IDLE;
      tmo_d    = '0;
      frame_ev = 1'b1;
    end
  end

  // FIFO bookkeeping: a pop needs data present, and a push into a full FIFO survives only alongside a pop.
  always_comb begin
    not_empty  = (count_q != '0);
    full       = (count_q == FULL_CNT);
    do_pop     = fifo.rd & not_empty;
    do_push    = push & (~full | do_pop);
    overrun_ev = push & full & ~do_pop;
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_comb begin
    frame_err_d  = (frame_err_q & ~clr_err) | frame_ev;
    parity_err_d = (parity_err_q & ~clr_err) | parity_ev;
    overrun_d    = (overrun_q & ~clr_err) | overrun_ev;
  end

  // State register for the whole receiver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kc_meta_q    <= 1'b1;
      kc_sync_q    <= 1'b1;
      kd_meta_q    <= 1'b1;
      kd_sync_q    <= 1'b1;
      filt_cnt_q   <= '0;
      kc_filt_q    <= 1'b1;
      kc_dly_q     <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      kc_meta_q    <= kc_meta_d;
      kc_sync_q    <= kc_sync_d;
      kd_meta_q    <= kd_meta_d;
      kd_sync_q    <= kd_sync_d;
      filt_cnt_q   <= filt_cnt_d;
      kc_filt_q    <= kc_filt_d;
      kc_dly_q     <= kc_dly_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // FIFO storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign fifo.valid  = not_empty;
  assign fifo.count  = count_q;
  assign fifo.rdata  = not_empty ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: table of single frames plus hand-written
// sequences for latency, overrun, timeout, bad start bit and mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_frame_rx;

  localparam int FILT = 8;
  localparam int DEPTH = 8;
  localparam int TMO = 200;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset, kc, kd, clr_err;
  logic frame_err, parity_err, overrun;
  logic valid_pre, valid_post;
  int n_checks = 0;
  int n_fail = 0;

  ps2_frame_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_frame_rx #(.FILTER_LEN(FILT), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .kc(kc), .kd(kd), .clr_err(clr_err),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
    .fifo(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       glitch;
    logic       exp_valid;
    logic       exp_frame;
    logic       exp_par;
  } vec_t;

  vec_t vecs [7];

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    kd = b;
    cycles(12);
    if (glitch) begin
      kc = 1'b0;
      cycles(3);
      kc = 1'b1;
    end else begin
      cycles(3);
    end
    cycles(HALF - 15);
    kc = 1'b0;
    cycles(HALF);
    kc = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic bad_par, input logic bad_stop,
                               input logic glitch, input logic rd_pulse);
    logic [10:0] bits;
    bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i], glitch);
    kd = bits[10];
    cycles(HALF);
    kc = 1'b0;
    cycles(10);
    valid_pre = bus.valid;
    if (rd_pulse) bus.rd = 1'b1;
    cycles(1);
    bus.rd = 1'b0;
    valid_post = bus.valid;
    cycles(HALF - 11);
    kc = 1'b1;
    cycles(HALF);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    checkOutput(name, {24'h0, bus.rdata}, {24'h0, exp});
    bus.rd = 1'b1;
    cycles(1);
    bus.rd = 1'b0;
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; kc = 1'b1; kd = 1'b1; clr_err = 1'b0; bus.rd = 1'b0;
    cycles(3);
    checkOutput("rst_valid", {31'h0, bus.valid}, 0);
    checkOutput("rst_count", {28'h0, bus.count}, 0);
    checkOutput("rst_rdata", {24'h0, bus.rdata}, 0);
    checkOutput("rst_flags", {29'h0, frame_err, parity_err, overrun}, 0);
    reset = 1'b0;
    cycles(2 * HALF);

    $display("[TB] push latency on frame 0x1C");
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_valid_before", {31'h0, valid_pre}, 0);
    checkOutput("lat_valid_after", {31'h0, valid_post}, 1);
    checkOutput("lat_count", {28'h0, bus.count}, 1);
    checkOutput("lat_flags", {29'h0, frame_err, parity_err, overrun}, 0);
    pop_check("lat_rdata", 8'h1C);
    checkOutput("lat_valid_popped", {31'h0, bus.valid}, 0);
    checkOutput("lat_count_popped", {28'h0, bus.count}, 0);

    $display("[TB] table of single frames");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, vecs[i].glitch, 1'b0);
      checkOutput($sformatf("vec%0d_valid", i), {31'h0, bus.valid}, {31'h0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d_frame_err", i), {31'h0, frame_err}, {31'h0, vecs[i].exp_frame});
      checkOutput($sformatf("vec%0d_parity_err", i), {31'h0, parity_err}, {31'h0, vecs[i].exp_par});
      if (vecs[i].exp_valid) pop_check($sformatf("vec%0d_rdata", i), vecs[i].data);
      clear_errors();
      checkOutput($sformatf("vec%0d_flags_cleared", i), {30'h0, frame_err, parity_err}, 0);
    end

    $display("[TB] pop while empty");
    bus.rd = 1'b1;
    cycles(1);
    bus.rd = 1'b0;
    checkOutput("empty_pop_count", {28'h0, bus.count}, 0);

    $display("[TB] start bit of 1");
    kd = 1'b1;
    cycles(HALF);
    kc = 1'b0;
    cycles(HALF);
    kc = 1'b1;
    cycles(HALF);
    checkOutput("badstart_frame_err", {31'h0, frame_err}, 1);
    checkOutput("badstart_valid", {31'h0, bus.valid}, 0);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    checkOutput("badstart_cleared", {31'h0, frame_err}, 0);

    $display("[TB] overrun");
    for (int b = 1; b <= 9; b++) begin
      applyStimulus(8'(b), 1'b0, 1'b0, 1'b0, 1'b0);
      if (b == 8) checkOutput("ovr_no_overrun_at_8", {31'h0, overrun}, 0);
    end
    checkOutput("ovr_count", {28'h0, bus.count}, 8);
    checkOutput("ovr_flag", {31'h0, overrun}, 1);
    clear_errors();
    applyStimulus(8'h0A, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("full_pushpop_count", {28'h0, bus.count}, 8);
    checkOutput("full_pushpop_overrun", {31'h0, overrun}, 0);
    for (int k = 0; k < 8; k++) pop_check($sformatf("drain%0d", k), (k < 7) ? 8'(k + 2) : 8'h0A);
    checkOutput("drain_valid", {31'h0, bus.valid}, 0);
    applyStimulus(8'h0B, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("empty_pushpop_count", {28'h0, bus.count}, 1);
    checkOutput("empty_pushpop_overrun", {31'h0, overrun}, 0);
    pop_check("empty_pushpop_rdata", 8'h0B);

    $display("[TB] timeout mid-frame");
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    kd = 1'b0;
    cycles(HALF);
    kc = 1'b0;
    cycles(10 + TMO);
    checkOutput("tmo_before", {31'h0, frame_err}, 0);
    cycles(1);
    checkOutput("tmo_at", {31'h0, frame_err}, 1);
    checkOutput("tmo_valid", {31'h0, bus.valid}, 0);
    kc = 1'b1;
    kd = 1'b1;
    cycles(2 * HALF);
    clear_errors();
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_tmo_count", {28'h0, bus.count}, 1);
    checkOutput("after_tmo_flags", {29'h0, frame_err, parity_err, overrun}, 0);
    pop_check("after_tmo_rdata", 8'h5A);

    $display("[TB] reset during parity bit");
    applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_count", {28'h0, bus.count}, 3);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    kd = 1'b1;
    cycles(5);
    reset = 1'b1;
    cycles(2);
    checkOutput("midrst_valid", {31'h0, bus.valid}, 0);
    checkOutput("midrst_count", {28'h0, bus.count}, 0);
    checkOutput("midrst_rdata", {24'h0, bus.rdata}, 0);
    checkOutput("midrst_flags", {29'h0, frame_err, parity_err, overrun}, 0);
    reset = 1'b0;
    cycles(2 * HALF);
    applyStimulus(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_count", {28'h0, bus.count}, 1);
    checkOutput("post_rst_flags", {29'h0, frame_err, parity_err, overrun}, 0);
    pop_check("post_rst_rdata", 8'h29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
